credit_queue_sender: RTL and testbench

- Transmit end of a credit-flow-controlled link.
- Accepts 8-bit items on a ready/valid enqueue port and forwards them one cycle later on a valid-only output channel to a remote receiving queue of DEPTH entries.
- Tracks free remote entries with a credit counter. The remote side returns one credit pulse per dequeued item.
- Sits between a local producer and a long or registered wire to a remote buffer, where a combinational ready path is not allowed.

---
 rtl/credit_queue_sender_if.sv | 28 ++
 rtl/credit_queue_sender.sv | 69 ++++++
 tb/tb_credit_queue_sender.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/credit_queue_sender_if.sv
// Link bundle between a local producer, the credit sender and the remote queue.
interface credit_queue_sender_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             io_enq_valid;
  logic             io_enq_ready;
  logic [WIDTH-1:0] io_enq_bits;
  logic             io_out_valid;
  logic [WIDTH-1:0] io_out_bits;
  logic             io_credit_return;
  logic [CW-1:0]    io_credits;
  logic             io_overflow;

  // Environment side: producer, remote credit source and observers.
  modport master (
    output io_enq_valid, io_enq_bits, io_credit_return,
    input  io_enq_ready, io_out_valid, io_out_bits, io_credits, io_overflow
  );

  // Sender side.
  modport slave (
    input  io_enq_valid, io_enq_bits, io_credit_return,
    output io_enq_ready, io_out_valid, io_out_bits, io_credits, io_overflow
  );
endinterface

// File: rtl/credit_queue_sender.sv
// Transmit end of a credit-flow-controlled link: accepts items while remote
// space is known to exist and forwards them one cycle later on a registered link.
module credit_queue_sender #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  credit_queue_sender_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CREDITS_MAX = CW'(DEPTH);

  logic [CW-1:0]    credits_q;
  logic [CW-1:0]    credits_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_bits_q;
  logic             ready;
  logic             fire;
  logic             ret;

  // Ready comes from register state only, so no combinational path from the link.
  assign ready = (credits_q != '0);
  assign fire  = bus.io_enq_valid & ready;
  assign ret   = bus.io_credit_return;

  // Net credit update; a return at full credit is dropped and flagged.
  always_comb begin
    credits_d  = credits_q;
    overflow_d = overflow_q;
    unique case ({fire, ret})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q == CREDITS_MAX) begin
          overflow_d = 1'b1;
        end else begin
          credits_d = credits_q + CW'(1);
        end
      end
      default: credits_d = credits_q;
    endcase
  end

  // Credit counter, sticky overflow flag and output link register.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q   <= CREDITS_MAX;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
    end else begin
      credits_q   <= credits_d;
      overflow_q  <= overflow_d;
      out_valid_q <= fire;
      if (fire) begin
        out_bits_q <= bus.io_enq_bits;
      end
    end
  end

  // Port drive.
  assign bus.io_enq_ready = ready;
  assign bus.io_out_valid = out_valid_q;
  assign bus.io_out_bits  = out_bits_q;
  assign bus.io_credits   = credits_q;
  assign bus.io_overflow  = overflow_q;
endmodule

// File: tb/tb_credit_queue_sender.sv
// Directed bench for credit_queue_sender with a scoreboard on the output link.
module tb_credit_queue_sender;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [WIDTH-1:0] exp_q[$];

  credit_queue_sender_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  credit_queue_sender #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check registered and ready state at the falling edge.
  task automatic chk_state(input string tag, input int credits, input int ready, input int ovf);
    @(negedge clk);
    chk({tag, " credits"},  int'(bus.io_credits),   credits);
    chk({tag, " ready"},    int'(bus.io_enq_ready), ready);
    chk({tag, " overflow"}, int'(bus.io_overflow),  ovf);
  endtask

  // Monitor: every strobe on the link must match the oldest expected item.
  always @(negedge clk) begin
    if (bus.io_out_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL link_unexpected: got valid with bits 0x%0h, expected no strobe at %0t", bus.io_out_bits, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (bus.io_out_bits !== e) begin
          n_errors++;
          $display("FAIL link_bits: got 0x%0h, expected 0x%0h at %0t", bus.io_out_bits, e, $time);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 20000");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.io_enq_valid = 1'b0;
    bus.io_enq_bits = '0;
    bus.io_credit_return = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 3; i++) begin
      chk_state("idle", 2, 1, 0);
      chk("idle out_valid", int'(bus.io_out_valid), 0);
      tick();
    end

    // Two back-to-back pushes drain both credits.
    bus.io_enq_valid = 1'b1;
    bus.io_enq_bits = 8'hA5;
    chk_state("push1", 2, 1, 0);
    exp_q.push_back(8'hA5);
    tick();
    bus.io_enq_bits = 8'h3C;
    chk_state("push2", 1, 1, 0);
    exp_q.push_back(8'h3C);
    tick();
    bus.io_enq_bits = 8'h77;
    chk_state("push3 blocked", 0, 0, 0);
    tick();
    chk("push3 out_valid", int'(bus.io_out_valid), 0);

    // Credit return at zero: ready rises only the next cycle.
    bus.io_enq_bits = 8'h11;
    bus.io_credit_return = 1'b1;
    chk_state("ret at zero", 0, 0, 0);
    tick();
    bus.io_credit_return = 1'b0;
    chk_state("after ret", 1, 1, 0);
    exp_q.push_back(8'h11);
    tick();
    bus.io_enq_valid = 1'b0;
    chk_state("after 0x11", 0, 0, 0);

    // Get back to one credit, then fire and return together.
    bus.io_credit_return = 1'b1;
    tick();
    bus.io_credit_return = 1'b0;
    chk_state("one credit", 1, 1, 0);
    bus.io_enq_valid = 1'b1;
    bus.io_enq_bits = 8'h5A;
    bus.io_credit_return = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    bus.io_enq_valid = 1'b0;
    chk_state("fire+ret", 1, 1, 0);
    chk("fire+ret out_valid", int'(bus.io_out_valid), 1);
    tick();
    bus.io_credit_return = 1'b0;
    chk_state("refill", 2, 1, 0);

    // Return while full: overflow sets and sticks.
    bus.io_credit_return = 1'b1;
    tick();
    bus.io_credit_return = 1'b0;
    chk_state("overflow", 2, 1, 1);
    bus.io_enq_valid = 1'b1;
    bus.io_enq_bits = 8'hC3;
    exp_q.push_back(8'hC3);
    tick();
    bus.io_enq_bits = 8'hE7;
    chk_state("ovf sticky", 1, 1, 1);
    exp_q.push_back(8'hE7);
    tick();

    // Reset while the link strobes and credits are exhausted.
    bus.io_enq_valid = 1'b0;
    reset = 1'b1;
    chk_state("pre reset", 0, 0, 1);
    chk("pre reset out_valid", int'(bus.io_out_valid), 1);
    tick();
    reset = 1'b0;
    chk_state("post reset", 2, 1, 0);
    chk("post reset out_valid", int'(bus.io_out_valid), 0);
    chk("post reset out_bits", int'(bus.io_out_bits), 0);
    tick();
    chk_state("post reset idle", 2, 1, 0);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
